fetch_stage: RTL and testbench

- IF stage of the 5-stage MIPS pipeline, directly upstream of the hazard-detection unit and feeding the IF/ID register it controls.
- Owns the PC, issues requests to instruction memory over a req/valid handshake, and loads the IF/ID pipeline register.
- Obeys hold, flush and branch-redirect commands from hazard detection: holdPC, IF_ID_Flush, isBranch, PC_offset.

---
 rtl/fetch_stage_pkg.sv | 32 +++
 rtl/fetch_stage_if.sv | 18 +
 rtl/fetch_stage_if_id_reg.sv | 33 +++
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_fetch_stage.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_pkg
// Purpose  : Shared IF-stage types, constants and branch-target helper.
// Revision : 1.0
// ============================================================================
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_SQUASH = 2'd1,
      S_FULL   = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc_plus4;
      logic        valid;
   } if_id_t;

   localparam logic [31:0] NOP_INST = 32'h0000_0000;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   // Word offset scaled to bytes; wraps modulo 2^32.
   function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                 input logic [31:0] offset,
                                                 input int unsigned shift);
      return pc_plus4 + (offset << shift);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Instruction-memory req/valid handshake between IF and imem.
// Revision : 1.0
// ============================================================================
interface fetch_stage_if;

   logic        req;
   logic [31:0] addr;
   logic [31:0] rdata;
   logic        valid;

   modport master (output req, output addr, input rdata, input valid);
   modport slave  (input req, input addr, output rdata, output valid);

endinterface
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register; flush beats load, neither means hold.
// Revision : 1.0
// ============================================================================
module if_id_reg
   import fetch_stage_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_load,
   input  logic   i_flush,
   input  if_id_t i_data,
   output if_id_t o_if_id
);

   if_id_t r_if_id;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_if_id <= '{inst: NOP_INST, pc_plus4: 32'h0, valid: 1'b0};
      end else if (i_flush) begin
         r_if_id.valid <= 1'b0;
      end else if (i_load) begin
         r_if_id <= i_data;
      end
   end

   assign o_if_id = r_if_id;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : MIPS IF stage: PC, imem handshake, skid buffer, IF/ID load.
// Revision : 1.0
// ============================================================================
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = fetch_stage_pkg::RESET_PC,
   parameter int unsigned OFFSET_SHIFT = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          holdPC,
   input  logic          IF_ID_Flush,
   input  logic          isBranch,
   input  logic [31:0]   PC_offset,
   input  logic [31:0]   branch_pc_plus4,
   fetch_stage_if.master imem,
   output logic [31:0]   inst_IF_ID,
   output logic [31:0]   pc_plus4_IF_ID,
   output logic          valid_IF_ID
);

   fetch_state_e r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_redir;
   logic [31:0]  r_skid_inst;
   logic [31:0]  r_skid_pc4;
   logic         r_run;

   logic [31:0]  w_pc_plus4;
   logic [31:0]  w_target;
   logic [31:0]  w_refetch;
   logic         w_load;
   logic         w_flush;
   if_id_t       w_load_data;
   if_id_t       w_if_id;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_target   = branch_target(branch_pc_plus4, PC_offset, OFFSET_SHIFT);
   assign w_refetch  = w_if_id.pc_plus4 - 32'd4;

   // r_run keeps req low until the first edge after reset release.
   assign imem.req  = r_run && (r_state != S_FULL);
   assign imem.addr = r_pc;

   always_comb begin
      w_load      = 1'b0;
      w_flush     = 1'b0;
      w_load_data = '{inst: imem.rdata, pc_plus4: w_pc_plus4, valid: 1'b1};
      if (r_run) begin
         case (r_state)
            S_FETCH: begin
               if (isBranch || IF_ID_Flush) begin
                  w_flush = 1'b1;
               end else if (!holdPC && imem.valid) begin
                  w_load = 1'b1;
               end
            end
            S_SQUASH: begin
               w_flush = IF_ID_Flush;
            end
            S_FULL: begin
               if (isBranch || IF_ID_Flush) begin
                  w_flush = 1'b1;
               end else if (!holdPC) begin
                  w_load      = 1'b1;
                  w_load_data = '{inst: r_skid_inst, pc_plus4: r_skid_pc4, valid: 1'b1};
               end
            end
            default: begin
               w_flush = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_FETCH;
         r_pc        <= RESET_PC;
         r_redir     <= RESET_PC;
         r_skid_inst <= NOP_INST;
         r_skid_pc4  <= 32'h0;
         r_run       <= 1'b0;
      end else if (!r_run) begin
         r_run <= 1'b1;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (isBranch) begin
                  if (imem.valid) begin
                     r_pc <= w_target;
                  end else begin
                     r_redir <= w_target;
                     r_state <= S_SQUASH;
                  end
               end else if (IF_ID_Flush && holdPC) begin
                  // Load-use: refetch the flushed instruction once the bus is free.
                  if (imem.valid) begin
                     r_pc <= w_refetch;
                  end else begin
                     r_redir <= w_refetch;
                     r_state <= S_SQUASH;
                  end
               end else if (IF_ID_Flush) begin
                  r_pc <= r_pc;
               end else if (holdPC) begin
                  if (imem.valid) begin
                     r_skid_inst <= imem.rdata;
                     r_skid_pc4  <= w_pc_plus4;
                     r_state     <= S_FULL;
                  end
               end else if (imem.valid) begin
                  r_pc <= w_pc_plus4;
               end
            end
            S_SQUASH: begin
               if (isBranch) begin
                  r_redir <= w_target;
               end
               if (imem.valid) begin
                  r_pc    <= isBranch ? w_target : r_redir;
                  r_state <= S_FETCH;
               end
            end
            S_FULL: begin
               if (isBranch) begin
                  r_pc    <= w_target;
                  r_state <= S_FETCH;
               end else if (IF_ID_Flush) begin
                  r_pc    <= r_skid_pc4 - 32'd4;
                  r_state <= S_FETCH;
               end else if (!holdPC) begin
                  r_pc    <= r_skid_pc4;
                  r_state <= S_FETCH;
               end
            end
            default: begin
               r_state <= S_FETCH;
            end
         endcase
      end
   end

   if_id_reg u_if_id_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_flush (w_flush),
      .i_data  (w_load_data),
      .o_if_id (w_if_id)
   );

   assign inst_IF_ID     = w_if_id.inst;
   assign pc_plus4_IF_ID = w_if_id.pc_plus4;
   assign valid_IF_ID    = w_if_id.valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage with a latency-modelled imem.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

   logic        clk             = 1'b0;
   logic        rst_n           = 1'b0;
   logic        holdPC          = 1'b0;
   logic        IF_ID_Flush     = 1'b0;
   logic        isBranch        = 1'b0;
   logic [31:0] PC_offset       = 32'h0;
   logic [31:0] branch_pc_plus4 = 32'h0;
   logic [31:0] inst_IF_ID;
   logic [31:0] pc_plus4_IF_ID;
   logic        valid_IF_ID;

   int n_checks = 0;
   int n_errors = 0;

   // Memory model controls and state
   int m_age      = 0;
   int m_need     = 1;
   int mem_lat    = 1;
   bit m_fresh    = 1'b1;
   bit m_prev_req = 1'b0;
   bit mem_manual = 1'b0;
   bit mem_rand   = 1'b0;
   bit man_valid  = 1'b0;

   fetch_stage_if imem_bus ();

   fetch_stage #(.RESET_PC(32'h0), .OFFSET_SHIFT(2)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .holdPC          (holdPC),
      .IF_ID_Flush     (IF_ID_Flush),
      .isBranch        (isBranch),
      .PC_offset       (PC_offset),
      .branch_pc_plus4 (branch_pc_plus4),
      .imem            (imem_bus),
      .inst_IF_ID      (inst_IF_ID),
      .pc_plus4_IF_ID  (pc_plus4_IF_ID),
      .valid_IF_ID     (valid_IF_ID)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
   endfunction

   // A request completes at the edge where req and valid are both high; the
   // first request after req rises waits at least two cycles.
   always @(negedge clk) begin
      if (m_prev_req && imem_bus.valid) m_age = 0;
      if (mem_manual) begin
         imem_bus.valid = man_valid;
         imem_bus.rdata = 32'hBAD0_BAD0;
         m_age = 0;
         m_fresh = 1'b1;
      end else if (!imem_bus.req) begin
         imem_bus.valid = 1'b0;
         imem_bus.rdata = 32'hDEAD_BEEF;
         m_age = 0;
         m_fresh = 1'b1;
      end else begin
         if (m_age == 0) begin
            m_need = mem_rand ? int'($urandom_range(4, 1)) : mem_lat;
            if (m_fresh && m_need < 2) m_need = 2;
            m_fresh = 1'b0;
         end
         m_age++;
         imem_bus.valid = (m_age >= m_need);
         imem_bus.rdata = (m_age >= m_need) ? mem_word(imem_bus.addr) : 32'hDEAD_BEEF;
      end
      m_prev_req = imem_bus.req;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int lat);
      rst_n = 1'b0; holdPC = 1'b0; IF_ID_Flush = 1'b0; isBranch = 1'b0;
      PC_offset = 32'h0; branch_pc_plus4 = 32'h0;
      mem_lat = lat; mem_manual = 1'b0; mem_rand = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (imem_bus.req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b expected 0", imem_bus.req); end
      n_checks++; if (valid_IF_ID !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", valid_IF_ID); end
      n_checks++; if (inst_IF_ID !== 32'h0) begin n_errors++; $display("FAIL reset_inst: got %h expected 00000000", inst_IF_ID); end
      n_checks++; if (pc_plus4_IF_ID !== 32'h0) begin n_errors++; $display("FAIL reset_pc4: got %h expected 00000000", pc_plus4_IF_ID); end
      @(negedge clk);
      #1 rst_n = 1'b1;
      #1;
      n_checks++; if (imem_bus.req !== 1'b0) begin n_errors++; $display("FAIL release_req_before_edge: got %b expected 0", imem_bus.req); end
      step();
      n_checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0) begin n_errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000", imem_bus.req, imem_bus.addr); end
   endtask

   task automatic test_stream();
      do_reset(1);
      step();
      for (int i = 0; i < 10 && valid_IF_ID !== 1'b1; i++) step();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (valid_IF_ID !== 1'b1 || pc_plus4_IF_ID !== 32'(4 * (i + 1)) || inst_IF_ID !== mem_word(32'(4 * i)) || imem_bus.addr !== 32'(4 * (i + 1))) begin
            n_errors++;
            $display("FAIL stream[%0d]: got valid=%b pc4=%h inst=%h addr=%h expected valid=1 pc4=%h inst=%h addr=%h", i, valid_IF_ID, pc_plus4_IF_ID, inst_IF_ID, imem_bus.addr, 32'(4 * (i + 1)), mem_word(32'(4 * i)), 32'(4 * (i + 1)));
         end
         step();
      end
   endtask

   task automatic test_hold_skid();
      logic [31:0] s_inst, s_pc4;
      do_reset(3);
      step();
      for (int i = 0; i < 40 && !(imem_bus.req && imem_bus.addr == 32'h8); i++) step();
      n_checks++; if (imem_bus.addr !== 32'h8) begin n_errors++; $display("FAIL hold_reach_addr8: got %h expected 00000008", imem_bus.addr); end
      s_inst = inst_IF_ID; s_pc4 = pc_plus4_IF_ID;
      step();
      holdPC = 1'b1;
      step();
      n_checks++; if (inst_IF_ID !== s_inst || pc_plus4_IF_ID !== s_pc4 || imem_bus.addr !== 32'h8 || imem_bus.req !== 1'b1) begin n_errors++; $display("FAIL hold_wait: got inst=%h pc4=%h addr=%h req=%b expected inst=%h pc4=%h addr=00000008 req=1", inst_IF_ID, pc_plus4_IF_ID, imem_bus.addr, imem_bus.req, s_inst, s_pc4); end
      step();
      n_checks++; if (imem_bus.req !== 1'b0 || inst_IF_ID !== s_inst || pc_plus4_IF_ID !== s_pc4) begin n_errors++; $display("FAIL hold_full: got req=%b inst=%h pc4=%h expected req=0 inst=%h pc4=%h", imem_bus.req, inst_IF_ID, pc_plus4_IF_ID, s_inst, s_pc4); end
      holdPC = 1'b0;
      step();
      n_checks++; if (valid_IF_ID !== 1'b1 || inst_IF_ID !== mem_word(32'h8) || pc_plus4_IF_ID !== 32'hC || imem_bus.addr !== 32'hC || imem_bus.req !== 1'b1) begin n_errors++; $display("FAIL hold_release: got valid=%b inst=%h pc4=%h addr=%h req=%b expected valid=1 inst=%h pc4=0000000c addr=0000000c req=1", valid_IF_ID, inst_IF_ID, pc_plus4_IF_ID, imem_bus.addr, imem_bus.req, mem_word(32'h8)); end
      for (int i = 0; i < 10 && pc_plus4_IF_ID == 32'hC; i++) step();
      n_checks++; if (pc_plus4_IF_ID !== 32'h10 || inst_IF_ID !== mem_word(32'hC)) begin n_errors++; $display("FAIL hold_next: got pc4=%h inst=%h expected pc4=00000010 inst=%h", pc_plus4_IF_ID, inst_IF_ID, mem_word(32'hC)); end
   endtask

   task automatic test_branch_idle();
      do_reset(1);
      step();
      for (int i = 0; i < 10 && valid_IF_ID !== 1'b1; i++) step();
      isBranch = 1'b1; branch_pc_plus4 = 32'h20; PC_offset = 32'hFFFF_FFFE;
      step();
      isBranch = 1'b0;
      n_checks++; if (valid_IF_ID !== 1'b0 || imem_bus.addr !== 32'h18) begin n_errors++; $display("FAIL branch_idle: got valid=%b addr=%h expected valid=0 addr=00000018", valid_IF_ID, imem_bus.addr); end
      for (int i = 0; i < 10 && valid_IF_ID !== 1'b1; i++) step();
      n_checks++; if (pc_plus4_IF_ID !== 32'h1C || inst_IF_ID !== mem_word(32'h18)) begin n_errors++; $display("FAIL branch_idle_target: got pc4=%h inst=%h expected pc4=0000001c inst=%h", pc_plus4_IF_ID, inst_IF_ID, mem_word(32'h18)); end
   endtask

   task automatic test_branch_pending();
      do_reset(3);
      step();
      for (int i = 0; i < 40 && !(imem_bus.req && imem_bus.addr == 32'h10); i++) step();
      isBranch = 1'b1; branch_pc_plus4 = 32'h40; PC_offset = 32'h4;
      step();
      isBranch = 1'b0;
      n_checks++; if (valid_IF_ID !== 1'b0 || imem_bus.addr !== 32'h10 || imem_bus.req !== 1'b1) begin n_errors++; $display("FAIL branch_pend_hold1: got valid=%b addr=%h req=%b expected valid=0 addr=00000010 req=1", valid_IF_ID, imem_bus.addr, imem_bus.req); end
      step();
      n_checks++; if (imem_bus.addr !== 32'h10 || imem_bus.req !== 1'b1) begin n_errors++; $display("FAIL branch_pend_hold2: got addr=%h req=%b expected addr=00000010 req=1", imem_bus.addr, imem_bus.req); end
      step();
      n_checks++; if (imem_bus.addr !== 32'h50 || valid_IF_ID !== 1'b0) begin n_errors++; $display("FAIL branch_pend_redirect: got addr=%h valid=%b expected addr=00000050 valid=0", imem_bus.addr, valid_IF_ID); end
      for (int i = 0; i < 10 && valid_IF_ID !== 1'b1; i++) step();
      n_checks++; if (pc_plus4_IF_ID !== 32'h54 || inst_IF_ID !== mem_word(32'h50)) begin n_errors++; $display("FAIL branch_pend_target: got pc4=%h inst=%h expected pc4=00000054 inst=%h", pc_plus4_IF_ID, inst_IF_ID, mem_word(32'h50)); end
   endtask

   task automatic test_load_use();
      do_reset(1);
      step();
      for (int i = 0; i < 20 && pc_plus4_IF_ID != 32'h14; i++) step();
      holdPC = 1'b1; IF_ID_Flush = 1'b1;
      step();
      holdPC = 1'b0; IF_ID_Flush = 1'b0;
      n_checks++; if (valid_IF_ID !== 1'b0 || imem_bus.addr !== 32'h10) begin n_errors++; $display("FAIL load_use_bubble: got valid=%b addr=%h expected valid=0 addr=00000010", valid_IF_ID, imem_bus.addr); end
      for (int i = 0; i < 10 && valid_IF_ID !== 1'b1; i++) step();
      n_checks++; if (pc_plus4_IF_ID !== 32'h14 || inst_IF_ID !== mem_word(32'h10)) begin n_errors++; $display("FAIL load_use_refetch: got pc4=%h inst=%h expected pc4=00000014 inst=%h", pc_plus4_IF_ID, inst_IF_ID, mem_word(32'h10)); end
   endtask

   task automatic test_async_reset();
      do_reset(3);
      step();
      for (int i = 0; i < 80 && !(imem_bus.req && imem_bus.addr == 32'h30); i++) step();
      step();
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (valid_IF_ID !== 1'b0 || inst_IF_ID !== 32'h0 || pc_plus4_IF_ID !== 32'h0 || imem_bus.req !== 1'b0) begin n_errors++; $display("FAIL async_clear: got valid=%b inst=%h pc4=%h req=%b expected all zero", valid_IF_ID, inst_IF_ID, pc_plus4_IF_ID, imem_bus.req); end
      mem_manual = 1'b1; man_valid = 1'b1;
      @(negedge clk);
      #1 rst_n = 1'b1;
      step();
      man_valid = 1'b0;
      n_checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0 || valid_IF_ID !== 1'b0) begin n_errors++; $display("FAIL async_restart: got req=%b addr=%h valid=%b expected req=1 addr=00000000 valid=0", imem_bus.req, imem_bus.addr, valid_IF_ID); end
      step();
      n_checks++; if (imem_bus.addr !== 32'h0 || valid_IF_ID !== 1'b0) begin n_errors++; $display("FAIL async_stale_valid: got addr=%h valid=%b expected addr=00000000 valid=0", imem_bus.addr, valid_IF_ID); end
      mem_manual = 1'b0;
      for (int i = 0; i < 20 && valid_IF_ID !== 1'b1; i++) step();
      n_checks++; if (pc_plus4_IF_ID !== 32'h4 || inst_IF_ID !== mem_word(32'h0)) begin n_errors++; $display("FAIL async_first_fetch: got pc4=%h inst=%h expected pc4=00000004 inst=%h", pc_plus4_IF_ID, inst_IF_ID, mem_word(32'h0)); end
   endtask

   // Random latency and stalls: the IF/ID stream must be 0,4,8,... in order,
   // stalls must freeze IF/ID, and a waiting request must keep its address.
   task automatic test_random();
      logic [31:0] exp_pc, p_inst, p_pc4, a_pre;
      logic        p_valid, v_pre, r_pre, hold;
      do_reset(1);
      mem_rand = 1'b1;
      step();
      exp_pc = 32'h0;
      p_inst = inst_IF_ID; p_pc4 = pc_plus4_IF_ID; p_valid = valid_IF_ID;
      for (int cyc = 0; cyc < 400; cyc++) begin
         hold = ($urandom_range(3, 0) == 0);
         holdPC = hold;
         @(negedge clk);
         #1;
         v_pre = imem_bus.valid; r_pre = imem_bus.req; a_pre = imem_bus.addr;
         step();
         if (hold) begin
            n_checks++; if (inst_IF_ID !== p_inst || pc_plus4_IF_ID !== p_pc4 || valid_IF_ID !== p_valid) begin n_errors++; $display("FAIL rand_hold_freeze cyc=%0d: got pc4=%h inst=%h valid=%b expected pc4=%h inst=%h valid=%b", cyc, pc_plus4_IF_ID, inst_IF_ID, valid_IF_ID, p_pc4, p_inst, p_valid); end
            if (r_pre && v_pre) begin
               n_checks++; if (imem_bus.req !== 1'b0) begin n_errors++; $display("FAIL rand_skid_req cyc=%0d: got req=%b expected 0", cyc, imem_bus.req); end
            end
         end else begin
            if (r_pre && v_pre) begin
               n_checks++; if (pc_plus4_IF_ID !== a_pre + 32'd4 || inst_IF_ID !== mem_word(a_pre) || valid_IF_ID !== 1'b1) begin n_errors++; $display("FAIL rand_accept cyc=%0d: got pc4=%h inst=%h valid=%b expected pc4=%h inst=%h valid=1", cyc, pc_plus4_IF_ID, inst_IF_ID, valid_IF_ID, a_pre + 32'd4, mem_word(a_pre)); end
            end
            if (valid_IF_ID === 1'b1 && pc_plus4_IF_ID !== p_pc4) begin
               n_checks++; if (pc_plus4_IF_ID !== exp_pc + 32'd4 || inst_IF_ID !== mem_word(exp_pc)) begin n_errors++; $display("FAIL rand_order cyc=%0d: got pc4=%h inst=%h expected pc4=%h inst=%h", cyc, pc_plus4_IF_ID, inst_IF_ID, exp_pc + 32'd4, mem_word(exp_pc)); end
               exp_pc = exp_pc + 32'd4;
            end
         end
         if (r_pre && !v_pre) begin
            n_checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== a_pre) begin n_errors++; $display("FAIL rand_addr_stable cyc=%0d: got req=%b addr=%h expected req=1 addr=%h", cyc, imem_bus.req, imem_bus.addr, a_pre); end
         end
         p_inst = inst_IF_ID; p_pc4 = pc_plus4_IF_ID; p_valid = valid_IF_ID;
      end
      holdPC = 1'b0;
      mem_rand = 1'b0;
      n_checks++; if (exp_pc < 32'd160) begin n_errors++; $display("FAIL rand_progress: got %0d instructions expected at least 40", exp_pc / 4); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_hold_skid();
      test_branch_idle();
      test_branch_pending();
      test_load_use();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
